// File: rtl/decoder_n_to_2n_seq.sv
// Registered N:2^N one-hot decoder with enable, stall and a sweep mode.
// Drives register-file write enables; the sweep walks every output once,
// one per cycle, so the register file can be cleared after reset.
module decoder_n_to_2n_seq #(
  parameter int N         = 5,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      x,
  input  logic              en,
  input  logic              stall,
  input  logic              sweep_start,
  output logic [(1<<N)-1:0] y,
  output logic              busy,
  output logic              sweep_done
);

  localparam int W = 1 << N;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  // Last index of the sweep; the terminal compare happens here, so the
  // counter never wraps.
  localparam logic [N-1:0] CNT_LAST  = {N{1'b1}};
  // With a hardwired-zero R0 the sweep starts at index 1.
  localparam logic [N-1:0] START_IDX = N'(SKIP_ZERO ? 1 : 0);

  logic [0:0]   state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [W-1:0] y_q;
  logic         done_q, done_d;

  // Index to decode into the pipeline register and whether any bit is set.
  logic [N-1:0] sel_idx;
  logic         sel_valid;
  logic [W-1:0] decode_d;

  // Next-state logic for the IDLE/SWEEP controller and the decode request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    sel_idx   = x;
    sel_valid = 1'b0;
    if (!stall) begin
      if (state_q == IDLE) begin
        if (sweep_start) begin
          // Sweep wins over the same-cycle en/x request.
          state_d   = SWEEP;
          cnt_d     = START_IDX;
          sel_idx   = START_IDX;
          sel_valid = 1'b1;
        end else begin
          sel_idx   = x;
          sel_valid = en && !(SKIP_ZERO && (x == '0));
        end
      end else begin
        if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          sel_valid = 1'b0;
          done_d    = 1'b1;
        end else begin
          cnt_d     = cnt_q + N'(1);
          sel_idx   = cnt_q + N'(1);
          sel_valid = 1'b1;
        end
      end
    end
  end

  // One comparator per output bit: at most one bit can match sel_idx.
  for (genvar gi = 0; gi < W; gi++) begin : g_decode
    assign decode_d[gi] = sel_valid && (sel_idx == N'(gi));
  end

  // Pipeline register and controller state; stall freezes everything and
  // only lets the done pulse drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (!stall) begin
        y_q <= decode_d;
      end
    end
  end

  assign y          = y_q;
  assign busy       = (state_q == SWEEP);
  assign sweep_done = done_q;

endmodule

// File: tb/tb_decoder_n_to_2n_seq.sv
// Self-checking bench: two instances (SKIP_ZERO=1 and SKIP_ZERO=0, N=5)
// share stimulus; a behavioural model per instance is compared every cycle,
// and directed steps pin literal values from the test plan.
module tb_decoder_n_to_2n_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  x = '0;
  logic        en = 1'b0;
  logic        stall = 1'b0;
  logic        sweep_start = 1'b0;

  logic [31:0] y_w [2];
  logic        busy_w [2];
  logic        done_w [2];

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  decoder_n_to_2n_seq #(.N(5), .SKIP_ZERO(1'b1)) dut_skip (
    .clk(clk), .rst(rst), .x(x), .en(en), .stall(stall),
    .sweep_start(sweep_start), .y(y_w[0]), .busy(busy_w[0]),
    .sweep_done(done_w[0])
  );

  decoder_n_to_2n_seq #(.N(5), .SKIP_ZERO(1'b0)) dut_noskip (
    .clk(clk), .rst(rst), .x(x), .en(en), .stall(stall),
    .sweep_start(sweep_start), .y(y_w[1]), .busy(busy_w[1]),
    .sweep_done(done_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sweep position as a plain integer, y as a shifted 1.
  int          m_pos  [2] = '{0, 0};
  bit          m_busy [2] = '{0, 0};
  logic [31:0] m_y    [2] = '{0, 0};
  bit          m_done [2] = '{0, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_pos[k] = 0; m_y[k] = '0; m_done[k] = 0;
      end else if (stall) begin
        m_done[k] = 0;
      end else if (!m_busy[k]) begin
        m_done[k] = 0;
        if (sweep_start) begin
          m_busy[k] = 1;
          m_pos[k]  = (k == 0) ? 1 : 0;
          m_y[k]    = 32'd1 << m_pos[k];
        end else if (en && !(k == 0 && x == 5'd0)) begin
          m_y[k] = 32'd1 << x;
        end else begin
          m_y[k] = '0;
        end
      end else begin
        if (m_pos[k] == 31) begin
          m_busy[k] = 0; m_y[k] = '0; m_done[k] = 1; m_pos[k] = 0;
        end else begin
          m_pos[k]  = m_pos[k] + 1;
          m_y[k]    = 32'd1 << m_pos[k];
          m_done[k] = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model plus the output invariants.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_y[%0d]", k), y_w[k], m_y[k]);
        chk($sformatf("model_busy[%0d]", k), 32'(busy_w[k]), 32'(m_busy[k]));
        chk($sformatf("model_done[%0d]", k), 32'(done_w[k]), 32'(m_done[k]));
        chk($sformatf("onehot0[%0d]", k), 32'($countones(y_w[k]) <= 1), 32'd1);
      end
      chk("skip_bit0", 32'(y_w[0][0]), 32'd0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  int sweep_cycles;

  initial begin
    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_y", y_w[0], 32'h0);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_done", 32'(done_w[0]), 32'd0);
    rst = 1'b0;

    // Plain decode, then disable
    en = 1'b1; x = 5'd5; tick();
    chk("dec_x5_skip", y_w[0], 32'h0000_0020);
    chk("dec_x5_noskip", y_w[1], 32'h0000_0020);
    en = 1'b0; tick();
    chk("dec_en0", y_w[0], 32'h0);

    // x=0 suppressed only with SKIP_ZERO
    en = 1'b1; x = 5'd0; tick();
    chk("dec_x0_skip", y_w[0], 32'h0);
    chk("dec_x0_noskip", y_w[1], 32'h0000_0001);

    // Full sweep with a same-cycle request that must be dropped
    en = 1'b1; x = 5'd7; sweep_start = 1'b1; tick();
    sweep_start = 1'b0;
    sweep_cycles = 1;
    chk("sweep_first", y_w[0], 32'h0000_0002);
    chk("sweep_busy", 32'(busy_w[0]), 32'd1);
    for (int k = 2; k <= 31; k++) begin
      if (k == 12) sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      sweep_cycles++;
      chk($sformatf("sweep_step%0d", k), y_w[0], 32'd1 << k);
      if (k == 8) begin
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("stall_hold_y", y_w[0], 32'h0000_0100);
          chk("stall_busy", 32'(busy_w[0]), 32'd1);
        end
        stall = 1'b0;
      end
    end
    chk("sweep_len", 32'(sweep_cycles), 32'd31);
    en = 1'b0; tick();
    chk("sweep_end_y", y_w[0], 32'h0);
    chk("sweep_end_busy", 32'(busy_w[0]), 32'd0);
    chk("sweep_end_done", 32'(done_w[0]), 32'd1);
    tick();
    chk("done_pulse_once", 32'(done_w[0]), 32'd0);
    tick();

    // Reset in the middle of a sweep
    sweep_start = 1'b1; tick();
    sweep_start = 1'b0;
    for (int k = 2; k <= 16; k++) tick();
    chk("pre_rst_y", y_w[0], 32'h0001_0000);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("midrst_y", y_w[0], 32'h0);
    chk("midrst_busy", 32'(busy_w[0]), 32'd0);
    chk("midrst_done", 32'(done_w[0]), 32'd0);
    en = 1'b1; x = 5'd3; tick();
    chk("post_rst_dec", y_w[0], 32'h0000_0008);

    // Stall on the terminal sweep cycle defers completion
    en = 1'b0; sweep_start = 1'b1; tick();
    sweep_start = 1'b0;
    for (int k = 2; k <= 31; k++) tick();
    chk("term_y", y_w[0], 32'h8000_0000);
    stall = 1'b1;
    for (int s = 0; s < 2; s++) begin
      tick();
      chk("term_stall_done", 32'(done_w[0]), 32'd0);
      chk("term_stall_y", y_w[0], 32'h8000_0000);
    end
    stall = 1'b0; tick();
    chk("term_release_done", 32'(done_w[0]), 32'd1);
    chk("term_release_y", y_w[0], 32'h0);
    tick();
    chk("term_done_once", 32'(done_w[0]), 32'd0);
    tick(); tick();

    // Randomised traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      stall       = ($urandom_range(0, 5) == 0);
      sweep_start = ($urandom_range(0, 19) == 0);
      en          = $urandom_range(0, 1) == 1;
      x           = 5'($urandom_range(0, 31));
      tick();
    end
    rst = 1'b0; stall = 1'b0; sweep_start = 1'b0; en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
